operand_loader: RTL and testbench

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/operand_loader.sv | 149 ++++++++++++++
 tb/tb_operand_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// Operand loader: requests an instruction, resolves its addressing mode
// (including zero-page indirect pointers) and presents opcode, operand and effective address.
module operand_loader #(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  instruction_ready,
  input  logic [REG_WIDTH-1:0]  instruction_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [REG_WIDTH-1:0]  y_in,
  input  logic [REG_WIDTH-1:0]  data_in,
  input  logic                  op_ready,
  output logic                  get_next,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  op_valid,
  output logic [REG_WIDTH-1:0]  opcode_out,
  output logic [REG_WIDTH-1:0]  operand_out,
  output logic [ADDR_WIDTH-1:0] ea_out
);

  // state   | meaning
  // IDLE/REQ/ARM | start, get_next pulse, settle     WAIT    | accept instruction
  // PTR_LO/HI    | read pointer bytes                PTR_CAP | form pointer EA
  // OP_RD/OP_CAP | read operand, capture it          PRESENT | hold outputs for execute
  typedef enum logic [3:0] {
    IDLE, REQ, ARM, WAIT, PTR_LO, PTR_HI, PTR_CAP, OP_RD, OP_CAP, PRESENT
  } state_t;

  localparam logic [2:0] MODE_ZPX_IND = 3'b000;
  localparam logic [2:0] MODE_IMM     = 3'b010;
  localparam logic [2:0] MODE_IND_Y   = 3'b100;

  state_t                state_q;
  logic                  get_next_q, mem_rd_q, op_valid_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q, ea_q;
  logic [REG_WIDTH-1:0]  opcode_q, operand_q, lo_q;

  logic [2:0]            mode_in_d;
  logic                  store_in_d, ptr_in_d, store_q_d;
  logic [REG_WIDTH-1:0]  ptr_inc_d;
  logic [ADDR_WIDTH-1:0] y_term_d, ptr_ea_d;

  assign mode_in_d  = instruction_in[4:2];
  assign store_in_d = (instruction_in[7:5] == 3'b100);
  assign ptr_in_d   = (mode_in_d == MODE_ZPX_IND) || (mode_in_d == MODE_IND_Y);
  assign store_q_d  = (opcode_q[7:5] == 3'b100);

  // Pointer high byte wraps within zero page; the sum with Y wraps at 16 bits.
  assign ptr_inc_d  = ea_q[REG_WIDTH-1:0] + REG_WIDTH'(1);
  assign y_term_d   = (opcode_q[4:2] == MODE_IND_Y) ? ADDR_WIDTH'(y_in) : '0;
  assign ptr_ea_d   = ADDR_WIDTH'({data_in, lo_q}) + y_term_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      get_next_q <= 1'b0;
      mem_rd_q   <= 1'b0;
      op_valid_q <= 1'b0;
      mem_addr_q <= '0;
      ea_q       <= '0;
      opcode_q   <= '0;
      operand_q  <= '0;
      lo_q       <= '0;
    end else begin
      get_next_q <= 1'b0;
      mem_rd_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q    <= REQ;
          get_next_q <= 1'b1;
        end
        REQ:  state_q <= ARM;
        ARM:  state_q <= WAIT;
        WAIT: begin
          if (instruction_ready) begin
            opcode_q  <= instruction_in;
            ea_q      <= addr_in;
            operand_q <= '0;
            if (mode_in_d == MODE_IMM) begin
              operand_q  <= addr_in[REG_WIDTH-1:0];
              op_valid_q <= 1'b1;
              state_q    <= PRESENT;
            end else if (ptr_in_d) begin
              mem_rd_q   <= 1'b1;
              mem_addr_q <= ADDR_WIDTH'(addr_in[REG_WIDTH-1:0]);
              state_q    <= PTR_LO;
            end else if (store_in_d) begin
              op_valid_q <= 1'b1;
              state_q    <= PRESENT;
            end else begin
              mem_rd_q   <= 1'b1;
              mem_addr_q <= addr_in;
              state_q    <= OP_RD;
            end
          end
        end
        PTR_LO: begin
          mem_rd_q   <= 1'b1;
          mem_addr_q <= ADDR_WIDTH'(ptr_inc_d);
          state_q    <= PTR_HI;
        end
        PTR_HI: begin
          lo_q    <= data_in;
          state_q <= PTR_CAP;
        end
        PTR_CAP: begin
          ea_q <= ptr_ea_d;
          if (store_q_d) begin
            op_valid_q <= 1'b1;
            state_q    <= PRESENT;
          end else begin
            mem_rd_q   <= 1'b1;
            mem_addr_q <= ptr_ea_d;
            state_q    <= OP_RD;
          end
        end
        OP_RD: state_q <= OP_CAP;
        OP_CAP: begin
          operand_q  <= data_in;
          op_valid_q <= 1'b1;
          state_q    <= PRESENT;
        end
        PRESENT: begin
          if (op_ready) begin
            op_valid_q <= 1'b0;
            get_next_q <= 1'b1;
            state_q    <= REQ;
          end
        end
        default: begin
          op_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign get_next    = get_next_q;
  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign op_valid    = op_valid_q;
  assign opcode_out  = opcode_q;
  assign operand_out = operand_q;
  assign ea_out      = ea_q;

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: directed instructions push expected
// presentations and memory reads; negedge monitors pop and compare.
module tb_operand_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instruction_ready;
  logic [7:0]  instruction_in;
  logic [15:0] addr_in;
  logic [7:0]  y_in;
  logic [7:0]  data_in;
  logic        op_ready;
  logic        get_next, mem_rd, op_valid;
  logic [15:0] mem_addr, ea_out;
  logic [7:0]  opcode_out, operand_out;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0]  op;
    logic [7:0]  opnd;
    logic [15:0] ea;
  } exp_t;

  exp_t        opq[$];
  logic [15:0] rdq[$];
  logic [7:0]  mem [0:65535];

  operand_loader #(.REG_WIDTH(8), .ADDR_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .instruction_ready(instruction_ready), .instruction_in(instruction_in),
    .addr_in(addr_in), .y_in(y_in), .data_in(data_in), .op_ready(op_ready),
    .get_next(get_next), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .op_valid(op_valid), .opcode_out(opcode_out), .operand_out(operand_out),
    .ea_out(ea_out)
  );

  always #5 clk = ~clk;

  // Memory returns read data in the cycle after the strobe.
  always @(posedge clk) if (mem_rd) data_in <= mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory read monitor
  always @(negedge clk) begin
    if (reset_n === 1'b1 && mem_rd === 1'b1) begin
      if (rdq.size() == 0) begin
        chk("unexpected_mem_rd", {16'h0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        chk("mem_rd_addr", {16'h0, mem_addr}, {16'h0, rdq.pop_front()});
      end
    end
  end

  // Presentation monitor: compares on op_valid rise, stability while held
  exp_t cur;
  bit   prev_valid = 1'b0;
  always @(negedge clk) begin
    if (reset_n !== 1'b1) begin
      prev_valid = 1'b0;
    end else begin
      if (op_valid === 1'b1 && !prev_valid) begin
        if (opq.size() == 0) begin
          chk("unexpected_op_valid", {8'h0, opcode_out, operand_out, 8'h0}, 32'hFFFF_FFFF);
        end else begin
          cur = opq.pop_front();
          chk("opcode_out", {24'h0, opcode_out}, {24'h0, cur.op});
          chk("operand_out", {24'h0, operand_out}, {24'h0, cur.opnd});
          chk("ea_out", {16'h0, ea_out}, {16'h0, cur.ea});
        end
      end else if (op_valid === 1'b1 && prev_valid) begin
        chk("present_stable", {opcode_out, operand_out, ea_out}, {cur.op, cur.opnd, cur.ea});
      end
      prev_valid = (op_valid === 1'b1);
    end
  end

  task automatic wait_get_next();
    int n = 0;
    while (get_next !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("get_next_seen", {31'h0, get_next}, 32'h1);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_get_next"}, {31'h0, get_next}, 32'h0);
    chk({tag, "_mem_rd"}, {31'h0, mem_rd}, 32'h0);
    chk({tag, "_mem_addr"}, {16'h0, mem_addr}, 32'h0);
    chk({tag, "_op_valid"}, {31'h0, op_valid}, 32'h0);
    chk({tag, "_opcode"}, {24'h0, opcode_out}, 32'h0);
    chk({tag, "_operand"}, {24'h0, operand_out}, 32'h0);
    chk({tag, "_ea"}, {16'h0, ea_out}, 32'h0);
  endtask

  // Release just after an edge: IDLE for one cycle, get_next in the second.
  task automatic release_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rel_cycle1_get_next", {31'h0, get_next}, 32'h0);
    @(negedge clk);
    chk("rel_cycle2_get_next", {31'h0, get_next}, 32'h1);
  endtask

  task automatic issue(input logic [7:0] op, input logic [15:0] addr, input logic [7:0] y,
                       input int lat, input int hold, input logic [7:0] exp_opnd,
                       input logic [15:0] exp_ea, input int nrd,
                       input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] r2);
    int n;
    wait_get_next();
    instruction_in    = op;
    addr_in           = addr;
    y_in              = y;
    instruction_ready = 1'b1;
    opq.push_back('{op: op, opnd: exp_opnd, ea: exp_ea});
    if (nrd > 0) rdq.push_back(r0);
    if (nrd > 1) rdq.push_back(r1);
    if (nrd > 2) rdq.push_back(r2);
    @(negedge clk);
    chk("get_next_one_cycle", {31'h0, get_next}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    // Now in the first cycle after the WAIT accept edge
    instruction_ready = 1'b0;
    instruction_in    = ~op;
    addr_in           = ~addr;
    n = 1;
    while (op_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, lat);
    repeat (hold) begin
      chk("no_get_next_in_present", {31'h0, get_next}, 32'h0);
      @(negedge clk);
    end
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    chk("get_next_after_accept", {31'h0, get_next}, 32'h1);
    chk("op_valid_dropped", {31'h0, op_valid}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h1234] = 8'h5A;
    mem[16'h00FF] = 8'hF8;
    mem[16'h0000] = 8'hFF;
    mem[16'hFFF8] = 8'h77;
    mem[16'h0008] = 8'h77;
    mem[16'h0080] = 8'h3C;
    mem[16'h0040] = 8'h00;
    mem[16'h0041] = 8'h20;
    mem[16'h2000] = 8'h99;
    mem[16'h0050] = 8'hF0;
    mem[16'h0051] = 8'h12;
    mem[16'h4567] = 8'hC3;
    mem[16'h0020] = 8'h34;
    mem[16'h0021] = 8'h12;

    reset_n = 1'b0;
    instruction_ready = 1'b0;
    instruction_in = 8'h00;
    addr_in = 16'h0000;
    y_in = 8'h00;
    data_in = 8'h00;
    op_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    release_reset();

    //    op     addr      y      lat hold operand ea        nrd reads
    issue(8'hA9, 16'h0042, 8'h00, 1, 0, 8'h42, 16'h0042, 0, 16'h0, 16'h0, 16'h0);
    issue(8'hBD, 16'h1234, 8'h00, 3, 5, 8'h5A, 16'h1234, 1, 16'h1234, 16'h0, 16'h0);
    issue(8'hB1, 16'h00FF, 8'h10, 6, 0, 8'h77, 16'h0008, 3, 16'h00FF, 16'h0000, 16'h0008);
    issue(8'h8D, 16'h0300, 8'h00, 1, 2, 8'h00, 16'h0300, 0, 16'h0, 16'h0, 16'h0);
    issue(8'hA5, 16'h0080, 8'h00, 3, 0, 8'h3C, 16'h0080, 1, 16'h0080, 16'h0, 16'h0);
    issue(8'hA1, 16'h0040, 8'h10, 6, 1, 8'h99, 16'h2000, 3, 16'h0040, 16'h0041, 16'h2000);
    issue(8'h91, 16'h0050, 8'h05, 4, 0, 8'h00, 16'h12F5, 2, 16'h0050, 16'h0051, 16'h0);
    issue(8'hB9, 16'h4567, 8'h00, 3, 0, 8'hC3, 16'h4567, 1, 16'h4567, 16'h0, 16'h0);

    // Reset asserted while in PTR_HI abandons the instruction
    wait_get_next();
    instruction_in    = 8'hB1;
    addr_in           = 16'h0020;
    y_in              = 8'h00;
    instruction_ready = 1'b1;
    rdq.push_back(16'h0020);
    rdq.push_back(16'h0021);
    repeat (3) @(negedge clk);
    instruction_ready = 1'b0;
    @(negedge clk);
    chk("ptr_hi_mem_rd", {31'h0, mem_rd}, 32'h1);
    chk("ptr_hi_mem_addr", {16'h0, mem_addr}, 32'h0021);
    #2 reset_n = 1'b0;
    #1 check_outputs_zero("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("midreset_hold");
    release_reset();

    issue(8'hA9, 16'h0011, 8'h00, 1, 0, 8'h11, 16'h0011, 0, 16'h0, 16'h0, 16'h0);

    repeat (4) @(negedge clk);
    chk("opq_drained", opq.size(), 0);
    chk("rdq_drained", rdq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
